// File: rtl/cart_rom_arbiter.sv
// cart_rom_arbiter: shares the single cart ROM read port between the CPU mapper
// path and a background auxiliary reader. One fixed-latency read is in flight at
// a time. The CPU has priority, but after AUX_MAX CPU grants while aux_req waits
// the auxiliary request is forced through.
module cart_rom_arbiter #(
    parameter int LAT     = 2,
    parameter int AUX_MAX = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_cpu,
    input  logic        cpu_req,
    input  logic [22:0] cpu_addr,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic        aux_req,
    input  logic [22:0] aux_addr,
    output logic        aux_ack,
    output logic [7:0]  aux_rdata,
    output logic        aux_valid,
    output logic        mem_rd,
    output logic [22:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_AUX = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C     = 4'(LAT);
    localparam logic [3:0] AUX_MAX_C = 4'(AUX_MAX);

    // Starvation counter increment that sticks at its maximum value.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [3:0]  lat_cnt_r, lat_nxt_s;
    logic [3:0]  starve_cnt_r, starve_nxt_s;
    logic        cpu_pend_r, pend_nxt_s;
    logic [22:0] cpu_addr_q_r, addr_q_nxt_s;
    logic        mem_rd_r, mem_rd_nxt_s;
    logic [22:0] mem_addr_r, mem_addr_nxt_s;
    logic [7:0]  cpu_rdata_r, cpu_rdata_nxt_s;
    logic        cpu_ready_r, cpu_ready_nxt_s;
    logic        aux_ack_r, aux_ack_nxt_s;
    logic [7:0]  aux_rdata_r, aux_rdata_nxt_s;
    logic        aux_valid_r, aux_valid_nxt_s;
    logic        busy_r;

    logic        cpu_done_s;
    logic        cpu_cap_s;
    logic        cpu_any_s;
    logic        starve_ok_s;
    logic [22:0] cpu_grant_addr_s;

    // Request qualification: a CPU completion frees the pending slot in the same
    // cycle, so a fresh request presented then is captured rather than lost.
    always_comb begin
        cpu_done_s       = (state_r == RD_CPU) && (lat_cnt_r == 4'd0);
        cpu_cap_s        = ce_cpu & cpu_req & (~cpu_pend_r | cpu_done_s);
        cpu_any_s        = cpu_pend_r | (ce_cpu & cpu_req);
        cpu_grant_addr_s = cpu_pend_r ? cpu_addr_q_r : cpu_addr;
        starve_ok_s      = (starve_cnt_r < AUX_MAX_C) | ~aux_req;
    end

    // Next-state, grant decision and completion handling.
    always_comb begin
        state_nxt_s     = state_r;
        lat_nxt_s       = lat_cnt_r;
        starve_nxt_s    = aux_req ? starve_cnt_r : 4'd0;
        pend_nxt_s      = cpu_pend_r;
        addr_q_nxt_s    = cpu_addr_q_r;
        mem_rd_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        cpu_rdata_nxt_s = cpu_rdata_r;
        cpu_ready_nxt_s = 1'b0;
        aux_ack_nxt_s   = 1'b0;
        aux_rdata_nxt_s = aux_rdata_r;
        aux_valid_nxt_s = 1'b0;

        if (cpu_cap_s) begin
            pend_nxt_s   = 1'b1;
            addr_q_nxt_s = cpu_addr;
        end else if (cpu_done_s) begin
            pend_nxt_s   = 1'b0;
            addr_q_nxt_s = cpu_addr_q_r;
        end else begin
            pend_nxt_s   = cpu_pend_r;
            addr_q_nxt_s = cpu_addr_q_r;
        end

        case (state_r)
            IDLE: begin
                if (cpu_any_s && starve_ok_s) begin
                    mem_rd_nxt_s   = 1'b1;
                    mem_addr_nxt_s = cpu_grant_addr_s;
                    lat_nxt_s      = LAT_C;
                    state_nxt_s    = RD_CPU;
                    starve_nxt_s   = aux_req ? sat_inc(starve_cnt_r) : 4'd0;
                end else if (aux_req) begin
                    mem_rd_nxt_s   = 1'b1;
                    mem_addr_nxt_s = aux_addr;
                    aux_ack_nxt_s  = 1'b1;
                    lat_nxt_s      = LAT_C;
                    state_nxt_s    = RD_AUX;
                    starve_nxt_s   = 4'd0;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            RD_CPU: begin
                if (lat_cnt_r != 4'd0) begin
                    lat_nxt_s = lat_cnt_r - 4'd1;
                end else begin
                    cpu_rdata_nxt_s = mem_rdata;
                    cpu_ready_nxt_s = 1'b1;
                    state_nxt_s     = IDLE;
                end
            end
            RD_AUX: begin
                if (lat_cnt_r != 4'd0) begin
                    lat_nxt_s = lat_cnt_r - 4'd1;
                end else begin
                    aux_rdata_nxt_s = mem_rdata;
                    aux_valid_nxt_s = 1'b1;
                    state_nxt_s     = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                lat_nxt_s   = 4'd0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight read silently.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            lat_cnt_r    <= 4'd0;
            starve_cnt_r <= 4'd0;
            cpu_pend_r   <= 1'b0;
            cpu_addr_q_r <= 23'd0;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= 23'd0;
            cpu_rdata_r  <= 8'd0;
            cpu_ready_r  <= 1'b0;
            aux_ack_r    <= 1'b0;
            aux_rdata_r  <= 8'd0;
            aux_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            lat_cnt_r    <= lat_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            cpu_pend_r   <= pend_nxt_s;
            cpu_addr_q_r <= addr_q_nxt_s;
            mem_rd_r     <= mem_rd_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            cpu_rdata_r  <= cpu_rdata_nxt_s;
            cpu_ready_r  <= cpu_ready_nxt_s;
            aux_ack_r    <= aux_ack_nxt_s;
            aux_rdata_r  <= aux_rdata_nxt_s;
            aux_valid_r  <= aux_valid_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign mem_rd    = mem_rd_r;
    assign mem_addr  = mem_addr_r;
    assign cpu_rdata = cpu_rdata_r;
    assign cpu_ready = cpu_ready_r;
    assign aux_ack   = aux_ack_r;
    assign aux_rdata = aux_rdata_r;
    assign aux_valid = aux_valid_r;
    assign busy      = busy_r;

endmodule
